// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider with sign fixup.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fixup,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c,
    output logic             res_dz_c
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high half / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend-quotient shifter
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_raw_q, a_raw_d;     // raw dividend for the divide-by-zero result
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic             signed_op, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff, sum;
    logic [W2-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Operand magnitudes and signs at load time.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = signed_op & src_a[WIDTH-1];
        b_neg     = signed_op & src_b[WIDTH-1];
        a_abs     = a_neg ? (~src_a + WIDTH'(1)) : src_a;
        b_abs     = b_neg ? (~src_b + WIDTH'(1)) : src_b;
    end

    // Load, one iteration step, or hold.
    always_comb begin
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

        if (load) begin
            is_div_d  = is_div;
            neg_res_d = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_d = a_neg;
            a_raw_d   = src_a;
            dz_d      = is_div & (src_b == '0);
            acc_hi_d  = '0;
            acc_lo_d  = is_div ? a_abs : b_abs;
            opnd_d    = is_div ? b_abs : a_abs;
        end else if (step) begin
            if (is_div_q) begin
                // Remainder is always below the divisor, so it fits WIDTH bits either way.
                if (!diff[WIDTH]) begin
                    acc_hi_d = diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi_d = sum[WIDTH:1];
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    // Two's-complement sign correction and divide-by-zero result, valid while fixup is high.
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res_q ? (~prod + W2'(1)) : prod;
        quot_fix = neg_res_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
        rem_fix  = neg_rem_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
        res_hi_c = '0;
        res_lo_c = '0;
        res_dz_c = 1'b0;
        if (fixup) begin
            res_dz_c = dz_q;
            if (dz_q) begin
                res_hi_c = a_raw_q;
                res_lo_c = '1;
            end else if (is_div_q) begin
                res_hi_c = rem_fix;
                res_lo_c = quot_fix;
            end else begin
                res_hi_c = prod_fix[W2-1:WIDTH];
                res_lo_c = prod_fix[WIDTH-1:0];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit: sequences iterative mul/div, owns HI/LO, raises pipeline stall.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_read,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             load_c, step_c, fixup_c;
    logic [WIDTH-1:0] res_hi_c, res_lo_c;
    logic             res_dz_c;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (load_c),
        .step     (step_c),
        .fixup    (fixup_c),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .res_hi_c (res_hi_c),
        .res_lo_c (res_lo_c),
        .res_dz_c (res_dz_c)
    );

    // Next state, counter, HI/LO update and datapath strobes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        load_c     = 1'b0;
        step_c     = 1'b0;
        fixup_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A start in the same cycle as MTHI/MTLO wins; the write is dropped.
                    load_c     = 1'b1;
                    div_zero_d = 1'b0;
                    count_d    = '0;
                    state_d    = (op[1] && (src_b == '0)) ? ST_FIXUP : ST_CALC;
                end else begin
                    if (hilo_we[1]) hi_d = hilo_wdata;
                    if (hilo_we[0]) lo_d = hilo_wdata;
                end
            end
            ST_CALC: begin
                step_c  = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    count_d = '0;
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                fixup_c    = 1'b1;
                hi_d       = res_hi_c;
                lo_d       = res_lo_c;
                div_zero_d = res_dz_c;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers; reset abandons any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign busy     = (state_q != ST_IDLE);
    assign stall    = busy & (start | hilo_read | (hilo_we != 2'b00));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_read;
    logic [1:0]  hilo_we;
    logic [31:0] hilo_wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_read  (hilo_read),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built on the language's own multiply/divide.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [31:0] sa, sbv;
        logic [63:0]        p;
        sa  = a;
        sbv = b;
        e.name     = $sformatf("op%0d_%h_%h", o, a, b);
        e.dz       = 1'b0;
        e.busy_cyc = 33;
        e.hi       = '0;
        e.lo       = '0;
        case (o)
            2'b00: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                    e.busy_cyc = 1;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else if (o == 2'b10) begin
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Commit monitor: pops the oldest expectation on every done pulse.
    always @(negedge clock) begin
        exp_t e;
        if (prev_done) check_eq("done_pulse_width", 64'(done), 64'(0));
        if (done === 1'b1) begin
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq({e.name, ".hi"}, 64'(hi), 64'(e.hi));
                check_eq({e.name, ".lo"}, 64'(lo), 64'(e.lo));
                check_eq({e.name, ".div_zero"}, 64'(div_zero), 64'(e.dz));
                check_eq({e.name, ".busy_cycles"}, 64'(busy_run), 64'(e.busy_cyc));
            end
        end
        if (busy === 1'b1) busy_run++;
        else busy_run = 0;
        prev_done = done;
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        sb_q.push_back(model(o, a, b));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sb_q.size() == 0 && !busy && !done) return;
        end
        check_eq("drain_timeout", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        m;
        logic        got_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hilo_read = 1'b0; hilo_we = 2'b00; hilo_wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_hi", 64'(hi), 64'(0));
        check_eq("rst_lo", 64'(lo), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_div_zero", 64'(div_zero), 64'(0));
        check_eq("rst_stall", 64'(stall), 64'(0));

        // Directed arithmetic vectors.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
        check_eq("multu_max_hi", 64'(hi), 64'(32'hFFFF_FFFE));
        check_eq("multu_max_lo", 64'(lo), 64'(32'h0000_0001));
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);         drain();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); drain();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         drain();
        check_eq("div_m7_2_lo", 64'(lo), 64'(32'hFFFF_FFFD));
        check_eq("div_m7_2_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        issue(2'b11, 32'd100, 32'd7);               drain();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); drain();
        issue(2'b11, 32'd5, 32'd0);                 drain();
        check_eq("dz_sticky", 64'(div_zero), 64'(1));
        check_eq("dz_hi_hold", 64'(hi), 64'(5));
        issue(2'b01, 32'd2, 32'd3);                 drain();
        check_eq("dz_cleared", 64'(div_zero), 64'(0));
        check_eq("multu_2_3_lo", 64'(lo), 64'(6));

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(3, 0));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(20, 0)) : $urandom;
            issue(ro, ra, rb);
            drain();
        end

        // MTHI/MTLO in IDLE.
        @(negedge clock); hilo_we = 2'b10; hilo_wdata = 32'hCAFE_0001;
        @(negedge clock); hilo_we = 2'b01; hilo_wdata = 32'h5555_AAAA;
        check_eq("mthi", 64'(hi), 64'(32'hCAFE_0001));
        @(negedge clock); hilo_we = 2'b00;
        check_eq("mtlo", 64'(lo), 64'(32'h5555_AAAA));

        // start and MTLO together: start wins, lo untouched while busy.
        @(negedge clock);
        start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3;
        hilo_we = 2'b11; hilo_wdata = 32'hDEAD_BEEF;
        sb_q.push_back(model(2'b01, 32'd2, 32'd3));
        @(negedge clock);
        start = 1'b0; hilo_we = 2'b00;
        check_eq("start_wins_lo", 64'(lo), 64'(32'h5555_AAAA));
        check_eq("start_wins_hi", 64'(hi), 64'(32'hCAFE_0001));
        drain();

        // MFHI and MTLO stalled during a MULT.
        m = model(2'b00, 32'hFFFF_FFF9, 32'd1234567);
        @(negedge clock);
        start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFF9; src_b = 32'd1234567;
        sb_q.push_back(m);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        hilo_read = 1'b1; hilo_we = 2'b01; hilo_wdata = 32'h0000_1234;
        #1 check_eq("stall_first", 64'(stall), 64'(1));
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                got_done = 1'b1;
                check_eq("stall_in_done", 64'(stall), 64'(0));
                break;
            end
            check_eq("stall_busy_read", 64'(stall), 64'(1));
        end
        check_eq("stall_done_seen", 64'(got_done), 64'(1));
        hilo_read = 1'b0;
        @(negedge clock);
        hilo_we = 2'b00;
        check_eq("mtlo_after_op", 64'(lo), 64'(32'h0000_1234));
        check_eq("mtlo_keeps_hi", 64'(hi), 64'(m.hi));
        drain();

        // Second start held mid-op is accepted on return to IDLE.
        @(negedge clock);
        start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'hFFFF_FFFB;
        sb_q.push_back(model(2'b00, 32'd7, 32'hFFFF_FFFB));
        @(negedge clock);
        op = 2'b11; src_a = 32'd1000; src_b = 32'd13;
        sb_q.push_back(model(2'b11, 32'd1000, 32'd13));
        #1 check_eq("stall_start_first", 64'(stall), 64'(1));
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                got_done = 1'b1;
                check_eq("stall_start_done", 64'(stall), 64'(0));
                break;
            end
            check_eq("stall_busy_start", 64'(stall), 64'(1));
        end
        check_eq("second_done_seen", 64'(got_done), 64'(1));
        @(negedge clock);
        start = 1'b0;
        check_eq("second_accepted", 64'(busy), 64'(1));
        drain();

        // Reset during CALC abandons the operation.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_hi", 64'(hi), 64'(0));
        check_eq("midrst_lo", 64'(lo), 64'(0));
        check_eq("midrst_done", 64'(done), 64'(0));
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        issue(2'b11, 32'd9, 32'd4); drain();
        check_eq("divu_9_4_lo", 64'(lo), 64'(2));
        check_eq("divu_9_4_hi", 64'(hi), 64'(1));

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO unit beside the EX-stage ALU. It executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, over 32 cycles.
- Owns the architectural HI/LO registers and services MFHI/MFLO/MTHI/MTLO.
- Drives a stall request that holds PC, IF/ID and ID/EX while an operation is in flight and a dependent or conflicting instruction sits in EX.
- Operands are the post-forwarding ALU sources, not the raw ID/EX register values.

Parameters:
WIDTH, 32, operand/HI/LO width; counter width = clog2(WIDTH).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  EX holds a mul/div op; sampled only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
src_a  input  WIDTH  forwarded rs operand (multiplicand/dividend).
src_b  input  WIDTH  forwarded rt operand (multiplier/divisor).
hilo_read  input  1  EX holds MFHI or MFLO.
hilo_we  input  2  bit1 MTHI, bit0 MTLO.
hilo_wdata  input  WIDTH  data for MTHI/MTLO.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  state != IDLE.
stall  output  1  busy & (start | hilo_read | hilo_we != 0); combinational.
done  output  1  one-cycle pulse when HI/LO are committed by an operation.
div_zero  output  1  sticky flag, last division had divisor 0.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, count=0, hi=0, lo=0, done=0, div_zero=0.
  - Reset mid-operation abandons the operation; no partial HI/LO commit.
- FSM states: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 at edge E0: latch |src_a|, |src_b| (absolute values for MULT/DIV, raw for unsigned ops), neg_res, neg_rem and op; clear div_zero.
  - Next state is CALC with count=0, except DIV/DIVU with src_b==0, which goes straight to FIXUP.
- CALC:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
  - count increments each edge; on the edge where count==WIDTH-1, go to FIXUP. Exactly WIDTH CALC cycles.
- FIXUP, one cycle:
  - Apply two's-complement sign correction.
  - MULT: {hi,lo} = neg_res ? -prod : prod.
  - DIV: lo = neg_res ? -quot : quot; hi = neg_rem ? -rem : rem, where neg_rem = sign of src_a.
  - Unsigned ops: no correction.
  - Divide by zero: hi = src_a latched, lo = all ones, div_zero=1.
  - Commit at the FIXUP edge; next state IDLE; done=1 for the following cycle only.
- Latency:
  - Normal op: start accepted at E0, commit at E(WIDTH+1), busy high for WIDTH+1 cycles.
  - Divide by zero: busy 1 cycle, commit at E1.
- start while busy: ignored and stalled. The pipeline holds the instruction and it is accepted in the first IDLE cycle.
- hilo_read while busy: stall until done. In the done cycle hi/lo are already final and stall=0.
- MTHI/MTLO:
  - Written in IDLE at the edge.
  - If start and hilo_we are both asserted in IDLE, start wins and the write is dropped (the pipeline never issues both).
  - While busy: stalled, no write.
- hi/lo hold their values in every cycle not listed above. MULT results satisfy the exact 64-bit product; DIV truncates toward zero.
- MIN_INT / -1: quotient wraps to 0x80000000, remainder 0; no flag.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings, WIDTH default.
- One natural sub-module: muldiv_datapath, holding the accumulator/shift registers, the add/subtract step and sign fixup, controlled by the FSM through step/load/fixup strobes.
- The FSM, counter, stall logic and HI/LO registers stay in muldiv_sequencer.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF: busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle.
- MULT -3*7: hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000: hi=0x40000000, lo=0.
- DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7: lo=0x0000000E, hi=0x00000002. DIV 0x80000000/-1: lo=0x80000000, hi=0.
- DIVU 5/0: busy 1 cycle, hi=5, lo=0xFFFFFFFF, div_zero=1. A following MULTU 2*3 clears div_zero and gives lo=6.
- hilo_read=1 from cycle 2 of a MULT: stall=1 every cycle until the done cycle, where stall=0. A second start asserted mid-op is accepted only after return to IDLE; MTLO 0x1234 mid-op is stalled, not written.
- reset asserted on CALC cycle 10: next cycle busy=0, hi=lo=0, done=0. A subsequent DIVU 9/4 gives lo=2, hi=1.
